// File: rtl/key_code_conditioner_if.sv
// Push-button side and lock-FSM side of the key code conditioner.
// The slave modport is the conditioner; the master modport is the board/lock side.
interface key_code_conditioner_if #(
    parameter int NUM_KEYS = 4
);
    logic [NUM_KEYS-1:0] key;
    logic [NUM_KEYS-1:0] code_out;
    logic                code_valid;
    logic                key_held;
    logic [NUM_KEYS-1:0] db_keys;

    modport slave (
        input  key,
        output code_out,
        output code_valid,
        output key_held,
        output db_keys
    );

    modport master (
        output key,
        input  code_out,
        input  code_valid,
        input  key_held,
        input  db_keys
    );
endinterface

// File: rtl/key_code_conditioner.sv
// Synchronises and debounces active-low push-buttons, ORs together every button
// seen during one press episode, and strobes the code out once on full release.
module key_code_conditioner #(
    parameter int NUM_KEYS        = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    key_code_conditioner_if.slave  bus
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;

    typedef enum logic [1:0] {IDLE, HELD, EMIT} state_t;

    logic [SYNC_STAGES-1:0][NUM_KEYS-1:0] sync_q, sync_d;
    logic [NUM_KEYS-1:0]                  sync_s;
    logic [CW-1:0]                        cnt_q, cnt_d;
    logic [NUM_KEYS-1:0]                  db_q, db_d;
    logic [NUM_KEYS-1:0]                  acc_q, acc_d;
    logic [NUM_KEYS-1:0]                  code_q, code_d;
    logic                                 valid_q, valid_d;
    state_t                               state_q, state_d;

    assign sync_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = ~bus.key;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // Any sample that matches the accepted value restarts the persistence count.
    always_comb begin
        cnt_d = cnt_q;
        db_d  = db_q;
        if (sync_s == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            db_d  = sync_s;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        code_d  = code_q;
        valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (db_q != '0) begin
                    state_d = HELD;
                    acc_d   = db_q;
                end
            end
            HELD: begin
                acc_d = acc_q | db_q;
                if (db_q == '0) begin
                    state_d = EMIT;
                    code_d  = acc_q;
                    valid_d = 1'b1;
                end
            end
            EMIT: begin
                // A new press seen here is picked up from IDLE on the next cycle.
                state_d = IDLE;
                acc_d   = '0;
            end
            default: begin
                state_d = IDLE;
                acc_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            db_q    <= '0;
            acc_q   <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            state_q <= IDLE;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
            acc_q   <= acc_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            state_q <= state_d;
        end
    end

    assign bus.db_keys    = db_q;
    assign bus.key_held   = (db_q != '0);
    assign bus.code_out   = code_q;
    assign bus.code_valid = valid_q;

endmodule

// File: tb/tb_key_code_conditioner.sv
// Directed bench for key_code_conditioner: reset, single press, bounce, chord,
// reset mid-press and back-to-back presses.
module tb_key_code_conditioner;
    logic clock;
    logic reset;
    int   tests;
    int   failed;
    int   n_strobe;
    int   n_consec;
    logic prev_valid;
    logic [3:0] last_code;

    key_code_conditioner_if #(.NUM_KEYS(4)) kif ();

    key_code_conditioner #(
        .NUM_KEYS(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (kif.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        n_strobe   = 0;
        n_consec   = 0;
        prev_valid = 1'b0;
        last_code  = '0;
    end

    always @(negedge clock) begin
        if (kif.code_valid === 1'b1) begin
            n_strobe++;
            last_code = kif.code_out;
            if (prev_valid === 1'b1) n_consec++;
        end
        prev_valid = kif.code_valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wait_strobe(output logic found);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick(1);
            if (kif.code_valid === 1'b1) found = 1'b1;
        end
    endtask

    int   base;
    logic found;
    logic [3:0] orv;

    initial begin
        tests = 0;
        failed = 0;
        reset = 1'b0;
        kif.key = 4'b0000;

        // Reset with all buttons pressed
        tick(3);
        check("rst_db", kif.db_keys, 4'h0);
        check("rst_code", kif.code_out, 4'h0);
        check("rst_valid", kif.code_valid, 1'b0);
        check("rst_held", kif.key_held, 1'b0);
        reset = 1'b1;
        tick(5);
        check("rel_db_early", kif.db_keys, 4'h0);
        tick(1);
        check("rel_db_6", kif.db_keys, 4'hF);
        check("rel_held", kif.key_held, 1'b1);
        check("rel_valid", kif.code_valid, 1'b0);
        kif.key = 4'b1111;
        tick(10);
        check("rel_strobes", n_strobe, 1);
        check("rel_code", last_code, 4'hF);

        // Clean single press
        base = n_strobe;
        kif.key = 4'b1110;
        tick(5);
        check("sp_db_early", kif.db_keys, 4'h0);
        tick(1);
        check("sp_db", kif.db_keys, 4'h1);
        check("sp_held", kif.key_held, 1'b1);
        tick(14);
        kif.key = 4'b1111;
        tick(6);
        check("sp_db_rel", kif.db_keys, 4'h0);
        check("sp_held_rel", kif.key_held, 1'b0);
        check("sp_valid_pre", kif.code_valid, 1'b0);
        tick(1);
        check("sp_valid", kif.code_valid, 1'b1);
        check("sp_code", kif.code_out, 4'h1);
        tick(1);
        check("sp_valid_post", kif.code_valid, 1'b0);
        check("sp_code_hold", kif.code_out, 4'h1);
        tick(5);
        check("sp_count", n_strobe - base, 1);

        // Bounce rejection
        base = n_strobe;
        orv = '0;
        for (int i = 0; i < 10; i++) begin
            kif.key = (i % 2 == 0) ? 4'b1110 : 4'b1111;
            tick(1);
            orv |= kif.db_keys;
        end
        kif.key = 4'b1111;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            orv |= kif.db_keys;
        end
        check("bn_db", orv, 4'h0);
        check("bn_count", n_strobe - base, 0);

        // Chord accumulation: key0, +key3, -key0, -key3
        base = n_strobe;
        kif.key = 4'b1110;
        tick(10);
        check("ch_db1", kif.db_keys, 4'h1);
        kif.key = 4'b0110;
        tick(10);
        check("ch_db9", kif.db_keys, 4'h9);
        kif.key = 4'b0111;
        tick(10);
        check("ch_db8", kif.db_keys, 4'h8);
        check("ch_nostrobe", n_strobe - base, 0);
        kif.key = 4'b1111;
        tick(10);
        check("ch_count", n_strobe - base, 1);
        check("ch_code", last_code, 4'h9);
        check("ch_code_out", kif.code_out, 4'h9);

        // Reset mid-press
        kif.key = 4'b0111;
        tick(12);
        check("rm_db", kif.db_keys, 4'h8);
        base = n_strobe;
        reset = 1'b0;
        #1;
        check("rm_db_clr", kif.db_keys, 4'h0);
        check("rm_code_clr", kif.code_out, 4'h0);
        check("rm_held_clr", kif.key_held, 1'b0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        tick(10);
        check("rm_db_again", kif.db_keys, 4'h8);
        check("rm_nostrobe", n_strobe - base, 0);
        kif.key = 4'b1111;
        tick(10);
        check("rm_count", n_strobe - base, 1);
        check("rm_code", last_code, 4'h8);

        // Back-to-back presses
        base = n_strobe;
        kif.key = 4'b1101;
        tick(10);
        kif.key = 4'b1111;
        wait_strobe(found);
        check("bb_found1", found, 1'b1);
        check("bb_code1", kif.code_out, 4'h2);
        kif.key = 4'b1011;
        tick(10);
        check("bb_db4", kif.db_keys, 4'h4);
        check("bb_hold2", kif.code_out, 4'h2);
        kif.key = 4'b1111;
        wait_strobe(found);
        check("bb_found2", found, 1'b1);
        check("bb_code2", kif.code_out, 4'h4);
        tick(3);
        check("bb_count", n_strobe - base, 2);
        check("no_consec_valid", n_consec, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/key_code_conditioner.md
Name: key_code_conditioner

Overview:
- Front-end input stage for the digital lock. Sits between the four raw active-low DE1-SoC push-buttons and the lock FSM's `key` input.
- Synchronises and debounces the buttons, and accumulates every button pressed during one press episode.
- On full release, emits a single-cycle strobe carrying the 4-bit key code.
- The lock FSM therefore sees exactly one clean code per press, never bounce or multi-cycle levels.

Parameters:
- NUM_KEYS, 4, number of push-buttons and width of the code.
- SYNC_STAGES, 2, flip-flop stages in the metastability synchroniser; legal range ≥2.
- DEBOUNCE_CYCLES, 4, consecutive cycles a changed input must persist before it is accepted; legal range ≥1 (board build uses 500000).

Ports:
- clock, input, 1, system clock; all state updates on posedge.
- reset, input, 1, asynchronous active-low reset; 0 clears all state immediately.
- key, input, NUM_KEYS, raw push-buttons, active-low (0 = pressed), asynchronous to clock.
- code_out, output, NUM_KEYS, accumulated key code of the last completed press; active-high bit per button.
- code_valid, output, 1, one-cycle strobe; code_out carries a new code in this cycle.
- key_held, output, 1, high while the debounced input is non-zero (any button accepted as pressed).
- db_keys, output, NUM_KEYS, debounced active-high button vector (debug/LED use).

Behaviour:
- Reset (reset=0, asynchronous):
  - Sync chain, debounce counter, db_keys, accumulator and code_out all clear to 0.
  - code_valid=0, key_held=0, FSM=IDLE.
  - Takes effect mid-press; no code is emitted for the interrupted press.
- Synchroniser: s = ~key passed through SYNC_STAGES flops; s is active-high.
- Debounce, on every edge:
  - If s == db_keys: cnt ← 0.
  - Else if cnt == DEBOUNCE_CYCLES−1: db_keys ← s, cnt ← 0.
  - Else: cnt ← cnt+1.
  - cnt width is clog2(DEBOUNCE_CYCLES)+1; it never wraps.
  - A single-cycle glitch back to db_keys restarts the count.
  - Pin-to-db_keys latency is exactly SYNC_STAGES + DEBOUNCE_CYCLES edges for a clean transition.
- key_held = (db_keys != 0), combinational from db_keys.
- FSM (registered):
  - IDLE: if db_keys != 0 → HELD, acc ← db_keys.
  - HELD: acc ← acc | db_keys each cycle. If db_keys == 0 → EMIT, code_out ← acc.
  - EMIT: code_valid=1 for exactly this cycle, then → IDLE. acc ← 0. If db_keys != 0 here, it is ignored this cycle and captured from IDLE next cycle.
- code_valid is a registered Moore output: high only in EMIT, never two consecutive cycles.
- code_out holds its value between strobes.
- Emitted codes:
  - Always non-zero (range 1..2^NUM_KEYS−1).
  - A chord (e.g. keys 0 and 3) emits the OR of all keys seen during the episode (4'b1001).
  - Sequential overlapping presses without an intermediate full release merge into one code.
- Release-to-strobe: code_valid is high in the cycle following the edge at which the FSM sees db_keys == 0, i.e. 1 cycle after db_keys falls to 0.
- Held forever: stays in HELD, no strobe, no timeout.
- Key held through reset release: db_keys rises after debounce and is treated as a new press.

Test Plan:
- Reset: reset=0 with key=4'b0000 (all pressed) → all outputs 0 during reset. Release reset with key held → db_keys=4'hF exactly 6 edges later, key_held=1, code_valid stays 0.
- Clean single press: key=4'b1110 for 20 cycles then 4'b1111 → db_keys=4'h1 six edges after press. One code_valid pulse with code_out=4'h1, one cycle after db_keys returns to 0. Exactly one pulse total.
- Bounce rejection: key toggles 4'b1110/4'b1111 every cycle for 10 cycles, then returns to 4'b1111 → db_keys stays 0, no code_valid.
- Chord accumulation: press key0 and hold, press key3 and hold, release key0, release key3 → single code_valid with code_out=4'h9.
- Reset mid-press: key=4'b0111 held 12 cycles, pulse reset low 1 cycle while still held, then release → no strobe from the first press. Re-debounced press yields code_out=4'h8 on release.
- Back-to-back presses: press/release 4'h2, then press 4'h4 immediately after the first strobe → two strobes, codes 4'h2 then 4'h4, with code_out holding 4'h2 between them.
